// File: rtl/contador_7seg_mux.sv
// Multi-digit up/down counter with a time-multiplexed 7-segment display.
// N_DIGITS cascaded digits in hex or BCD. A prescaler sets the count rate and
// a scan divider sets how long each digit is shown. The decimal point of
// digit 0 shows the wrap indicator.
// Optional build macro: CONTADOR_SATURATE_EN. When it is defined, the counter
// saturates at its end values instead of wrapping.
// Contains the shared segment decoder decodificador_7seg and the top module.

module decodificador_7seg (
  input  logic [3:0] entrada,
  input  logic       dp,
  output logic [7:0] saida
);

  logic [6:0] seg_s;

  // Hex digit to segments {g,f,e,d,c,b,a}, active-high
  always_comb begin
    seg_s = 7'h00;
    case (entrada)
      4'h0:    seg_s = 7'h3F;
      4'h1:    seg_s = 7'h06;
      4'h2:    seg_s = 7'h5B;
      4'h3:    seg_s = 7'h4F;
      4'h4:    seg_s = 7'h66;
      4'h5:    seg_s = 7'h6D;
      4'h6:    seg_s = 7'h7D;
      4'h7:    seg_s = 7'h07;
      4'h8:    seg_s = 7'h7F;
      4'h9:    seg_s = 7'h6F;
      4'hA:    seg_s = 7'h77;
      4'hB:    seg_s = 7'h7C;
      4'hC:    seg_s = 7'h39;
      4'hD:    seg_s = 7'h5E;
      4'hE:    seg_s = 7'h79;
      4'hF:    seg_s = 7'h71;
      default: seg_s = 7'h00;
    endcase
  end

  assign saida = {dp, seg_s};

endmodule

module contador_7seg_mux #(
  parameter int N_DIGITS = 4,
  parameter int BCD      = 1,
  parameter int PRESCALE = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clear,
  output logic [7:0]            leds,
  output logic [N_DIGITS-1:0]   an,
  output logic [4*N_DIGITS-1:0] value,
  output logic                  wrap_flag,
  output logic                  overflow
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);
  localparam logic [IX_W-1:0] IX_LAST = IX_W'(N_DIGITS - 1);
  localparam logic [3:0]      DMAX    = (BCD != 0) ? 4'd9 : 4'd15;

  logic [PS_W-1:0]       presc_q, presc_d;
  logic [4*N_DIGITS-1:0] value_q, value_d;
  logic                  wrap_q, wrap_d;
  logic                  ovf_q, ovf_d;
  logic [SC_W-1:0]       scan_q, scan_d;
  logic [IX_W-1:0]       idx_q, idx_d;
  logic [N_DIGITS-1:0]   an_q, an_d;

  logic                  tick_s;
  logic [4*N_DIGITS-1:0] cnt_next_s;
  logic                  full_wrap_s;
  logic                  chain_s;
  logic [3:0]            dig_s;
  logic [3:0]            digit_s;
  logic                  dp_s;

  assign tick_s = en && (presc_q == PS_LAST);

  // Ripple carry/borrow through the digits; a chain that survives every digit is a full wrap
  always_comb begin
    cnt_next_s = value_q;
    chain_s    = 1'b1;
    dig_s      = 4'd0;
    for (int i = 0; i < N_DIGITS; i++) begin
      dig_s = value_q[4*i +: 4];
      if (chain_s) begin
        if (up_dn) begin
          // Values at or above DMAX (including unreachable BCD codes) roll to 0 with carry
          if (dig_s >= DMAX) begin
            cnt_next_s[4*i +: 4] = 4'd0;
            chain_s              = 1'b1;
          end else begin
            cnt_next_s[4*i +: 4] = dig_s + 4'd1;
            chain_s              = 1'b0;
          end
        end else begin
          if (dig_s == 4'd0) begin
            cnt_next_s[4*i +: 4] = DMAX;
            chain_s              = 1'b1;
          end else if ((BCD != 0) && (dig_s > 4'd9)) begin
            cnt_next_s[4*i +: 4] = DMAX;
            chain_s              = 1'b0;
          end else begin
            cnt_next_s[4*i +: 4] = dig_s - 4'd1;
            chain_s              = 1'b0;
          end
        end
      end else begin
        cnt_next_s[4*i +: 4] = dig_s;
      end
    end
    full_wrap_s = chain_s;
  end

  // Next state of prescaler, digits, wrap flag and overflow pulse (clear beats tick)
  always_comb begin
    presc_d = presc_q;
    value_d = value_q;
    wrap_d  = wrap_q;
    ovf_d   = 1'b0;
    if (clear) begin
      presc_d = {PS_W{1'b0}};
      value_d = {(4*N_DIGITS){1'b0}};
      wrap_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (tick_s) begin
      presc_d = {PS_W{1'b0}};
      ovf_d   = full_wrap_s;
`ifdef CONTADOR_SATURATE_EN
      // At an end value the count holds and the wrap flag does not toggle
      if (full_wrap_s) begin
        value_d = value_q;
      end else begin
        value_d = cnt_next_s;
      end
      wrap_d = wrap_q;
`else
      value_d = cnt_next_s;
      wrap_d  = wrap_q ^ full_wrap_s;
`endif
    end else if (en) begin
      presc_d = presc_q + PS_W'(1);
    end else begin
      presc_d = presc_q;
    end
  end

  // Count-side state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= {PS_W{1'b0}};
      value_q <= {(4*N_DIGITS){1'b0}};
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      value_q <= value_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  // Free-running scan divider and digit index, and the one-hot select they imply
  always_comb begin
    scan_d = scan_q;
    idx_d  = idx_q;
    an_d   = {N_DIGITS{1'b0}};
    if (scan_q == SC_LAST) begin
      scan_d = {SC_W{1'b0}};
      if (idx_q == IX_LAST) begin
        idx_d = {IX_W{1'b0}};
      end else begin
        idx_d = idx_q + IX_W'(1);
      end
    end else begin
      scan_d = scan_q + SC_W'(1);
      idx_d  = idx_q;
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      an_d[i] = (idx_d == IX_W'(i));
    end
  end

  // Scan-side state register; clear does not touch it
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_q <= {SC_W{1'b0}};
      idx_q  <= {IX_W{1'b0}};
      an_q   <= {{(N_DIGITS-1){1'b0}}, 1'b1};
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
    end
  end

  // Pick the selected digit with an AND-OR mux; dp carries the wrap flag on digit 0
  always_comb begin
    digit_s = 4'd0;
    for (int i = 0; i < N_DIGITS; i++) begin
      digit_s = digit_s | (value_q[4*i +: 4] & {4{idx_q == IX_W'(i)}});
    end
    dp_s = wrap_q & (idx_q == {IX_W{1'b0}});
  end

  decodificador_7seg u_dec (
    .entrada (digit_s),
    .dp      (dp_s),
    .saida   (leds)
  );

  assign an        = an_q;
  assign value     = value_q;
  assign wrap_flag = wrap_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/contador_7seg_mux.md
Name: contador_7seg_mux

Overview:
- Parametrised multi-digit up/down counter driving a time-multiplexed 7-segment display.
- Replaces the single-digit free-running hex counter with these additions:
  - N cascaded digits, hex or BCD modulus, count enable and direction.
  - Clock prescaler for the count rate.
  - Digit-scan multiplexer.
  - Wrap indicator on the decimal point of digit 0.
- Each digit is encoded to segments by the existing decodificador_7seg (entrada[3:0], dp, saida[7:0]), one shared instance after the scan mux.

Parameters:
- N_DIGITS, 4, number of cascaded digits (1..8).
- BCD, 1, 1: each digit counts 0..9; 0: each digit counts 0..15.
- PRESCALE, 50000000, clk cycles per count tick (>=1; 1 = tick every enabled cycle).
- SCAN_DIV, 50000, clk cycles each digit is displayed (>=1).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; 0 freezes prescaler and digits.
- up_dn  in  1  1 = count up, 0 = count down; sampled on the tick cycle.
- clear  in  1  synchronous clear of count state.
- leds  out  8  segments + dp of the currently selected digit (decoder output, unmodified polarity).
- an  out  N_DIGITS  one-hot digit select, active-high, bit i = digit i.
- value  out  4*N_DIGITS  registered digit vector, digit i at [4i+3:4i].
- wrap_flag  out  1  toggles on every full-counter wrap.
- overflow  out  1  one-cycle pulse on the tick that wraps.

Behaviour:
- Reset (clk edge with reset=1):
  - Outputs: value=0, wrap_flag=0, overflow=0, an=1 (digit 0).
  - Internal: prescaler=0, scan counter=0, scan index=0.
- Priority: reset > clear > tick.
- Clear (reset=0, clear=1):
  - Effect: value=0, wrap_flag=0, prescaler=0, overflow=0.
  - Scan logic is unaffected.
- Prescaler:
  - When en=1: increments 0..PRESCALE-1, then returns to 0.
  - tick = en && prescaler==PRESCALE-1.
  - When en=0: prescaler holds and no tick occurs.
- Count on tick, with DMAX = BCD?9:15:
  - up: digit 0 increments. Digit i>0 increments only if all digits 0..i-1 are at DMAX. A digit at DMAX that increments becomes 0.
  - down: digit 0 decrements. Digit i>0 decrements only if all lower digits are 0. A digit at 0 that decrements becomes DMAX.
- Full wrap:
  - Condition: up with all digits at DMAX (result all 0), or down with all digits 0 (result all DMAX).
  - On that tick edge: wrap_flag toggles and overflow=1 for exactly one cycle.
- overflow is 0 on every other cycle.
- Latency: value, wrap_flag and overflow update on the same edge as the tick.
- BCD=1, illegal digit value (10..15, unreachable): next increment forces 0 with carry out; decrement forces 9.
- Scan:
  - Scan counter runs 0..SCAN_DIV-1 continuously, independent of en.
  - At SCAN_DIV-1, the scan index advances 0..N_DIGITS-1, then back to 0.
  - an = 1<<index, registered.
- Segment path:
  - leds = decode(digit[index], dp), combinational from registered index/value.
  - dp = wrap_flag when index==0, else 0.
- N_DIGITS=1: an is constantly 1.
- Simultaneous clear and tick: clear wins, no overflow pulse.

Optional Feature:
- Macro: CONTADOR_SATURATE_EN.
- Defined:
  - Counting saturates: an up tick with all digits at DMAX, or a down tick with all digits 0, leaves value unchanged.
  - wrap_flag does not toggle.
  - overflow still pulses once per such saturating tick.
- Undefined: wrap-around behaviour as above.

Test Plan:
- Reset, BCD=1, N_DIGITS=2, PRESCALE=2, en=1, up_dn=1, 20 ticks:
  - Required: value=0x20.
  - After 99 ticks total from reset: value=0x99.
  - Next tick: value=0x00, wrap_flag=1, overflow high exactly 1 cycle.
- BCD=0, N_DIGITS=2, from reset, up_dn=0, one tick:
  - Required: value=0xFF, wrap_flag=1, overflow pulse.
  - Next tick: 0xFE.
- en toggled low mid-count (prescaler=1 of PRESCALE=3):
  - Required: value and prescaler frozen for 10 cycles.
  - Count resumes exactly 1 enabled cycle after en=1.
- clear asserted on a tick cycle at value=0x47, wrap_flag=1:
  - Required: next value=0x00, wrap_flag=0, overflow=0.
  - an sequence continues uninterrupted.
- SCAN_DIV=3, N_DIGITS=4:
  - Required: an steps 0001→0010→0100→1000→0001 every 3 cycles.
  - leds matches the decoder of the selected digit; dp lit only on digit 0 when wrap_flag=1.
- With CONTADOR_SATURATE_EN, BCD=1, N_DIGITS=2, at 0x99 up tick:
  - Required: value stays 0x99, wrap_flag unchanged, overflow pulses.
  - Mid-run reset returns all outputs to reset values on the next edge.
